usb_tx_engine: RTL

//  Parametrised USB full-speed packet transmitter: SYNC, PID, payload from TX FIFO, CRC16, EOP.

---
 rtl/usb_tx_engine.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/usb_tx_engine.sv
// USB full-speed packet transmitter: SYNC, PID, FIFO payload, CRC16 and EOP, NRZI encoded
// with bit stuffing, driving the D+/D- pad outputs.
module usb_tx_engine #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned STUFF_LIMIT  = 6,
    parameter int unsigned OCC_W        = 7,
    parameter int unsigned MAX_PAYLOAD  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       tx_packet,
    input  logic [7:0]       tx_packet_data,
    input  logic [OCC_W-1:0] buffer_occupancy,
    output logic             get_tx_packet_data,
    output logic             dp_out,
    output logic             dm_out,
    output logic             tx_transfer_active,
    output logic             tx_done,
    output logic             tx_error
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam int unsigned OW = $clog2(STUFF_LIMIT + 1);
    localparam int unsigned BW = $clog2(MAX_PAYLOAD + 1);

    localparam logic [TW-1:0] TimerLast = TW'(CLKS_PER_BIT - 1);
    localparam logic [OW-1:0] OnesLimit = OW'(STUFF_LIMIT);
    localparam logic [BW-1:0] ByteLimit = BW'(MAX_PAYLOAD);

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StPid,
        StData,
        StCrcLo,
        StCrcHi,
        StEop
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [7:0]      sh_q, sh_d;
    logic [2:0]      bit_q, bit_d;
    logic [OW-1:0]   ones_q, ones_d;
    logic [15:0]     crc_q, crc_d;
    logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [3:0]      pid_q, pid_d;
    logic [1:0]      eop_q, eop_d;
    logic            lvl_q, lvl_d;
    logic            dp_q, dp_d;
    logic            dm_q, dm_d;
    logic            err_q, err_d;

    logic            bit_strobe;
    logic            pid_is_data;
    logic            pid_valid;
    logic [3:0]      pid_new;
    logic            pop;
    logic            load_en;
    logic            load_bit;
    logic            crc_en;
    logic            to_eop;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic [15:0] s;
        s = {1'b0, c[15:1]};
        if (c[0] ^ b) begin
            s = s ^ 16'hA001;
        end
        return s;
    endfunction

    assign bit_strobe  = (state_q != StIdle) && (timer_q == TimerLast);
    // DATA0/DATA1 PIDs end in 2'b11, handshakes in 2'b10
    assign pid_is_data = (pid_q[1:0] == 2'b11);

    always_comb begin
        pid_valid = 1'b1;
        pid_new   = 4'h0;
        case (tx_packet)
            3'd1:    pid_new = 4'h3;
            3'd2:    pid_new = 4'hB;
            3'd3:    pid_new = 4'h2;
            3'd4:    pid_new = 4'hA;
            3'd5:    pid_new = 4'hE;
            default: pid_valid = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        sh_d       = sh_q;
        bit_d      = bit_q;
        ones_d     = ones_q;
        crc_d      = crc_q;
        byte_cnt_d = byte_cnt_q;
        pid_d      = pid_q;
        eop_d      = eop_q;
        lvl_d      = lvl_q;
        dp_d       = dp_q;
        dm_d       = dm_q;
        err_d      = err_q;
        pop        = 1'b0;
        load_en    = 1'b0;
        load_bit   = 1'b0;
        crc_en     = 1'b0;
        to_eop     = 1'b0;

        if (state_q != StIdle) begin
            timer_d = bit_strobe ? '0 : timer_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (pid_valid) begin
                    state_d    = StSync;
                    pid_d      = pid_new;
                    err_d      = 1'b0;
                    timer_d    = '0;
                    sh_d       = 8'h80;
                    bit_d      = '0;
                    ones_d     = '0;
                    crc_d      = 16'hFFFF;
                    byte_cnt_d = '0;
                    eop_d      = '0;
                    // First SYNC bit is a 0, so the line moves from J to K immediately
                    lvl_d      = 1'b0;
                    dp_d       = 1'b0;
                    dm_d       = 1'b1;
                end else if (tx_packet[2:1] == 2'b11) begin
                    err_d = 1'b1;
                end
            end

            StEop: begin
                if (bit_strobe) begin
                    case (eop_q)
                        2'd0: eop_d = 2'd1;
                        2'd1: begin
                            eop_d = 2'd2;
                            lvl_d = 1'b1;
                            dp_d  = 1'b1;
                            dm_d  = 1'b0;
                        end
                        default: state_d = StIdle;
                    endcase
                end
            end

            default: begin
                if (bit_strobe) begin
                    if (ones_q == OnesLimit) begin
                        // Stuffed 0: shifter and CRC hold
                        load_en  = 1'b1;
                        load_bit = 1'b0;
                    end else if (bit_q != 3'd7) begin
                        sh_d     = {1'b0, sh_q[7:1]};
                        bit_d    = bit_q + 1'b1;
                        load_en  = 1'b1;
                        load_bit = sh_q[1];
                        crc_en   = (state_q == StData);
                    end else begin
                        bit_d   = '0;
                        load_en = 1'b1;
                        case (state_q)
                            StSync: begin
                                state_d = StPid;
                                sh_d    = {~pid_q, pid_q};
                            end
                            StPid, StData: begin
                                if (state_q == StPid && !pid_is_data) begin
                                    to_eop = 1'b1;
                                end else if (buffer_occupancy != '0) begin
                                    if (state_q == StData && byte_cnt_q == ByteLimit) begin
                                        err_d  = 1'b1;
                                        to_eop = 1'b1;
                                    end else begin
                                        pop        = 1'b1;
                                        sh_d       = tx_packet_data;
                                        byte_cnt_d = byte_cnt_q + 1'b1;
                                        state_d    = StData;
                                        crc_en     = 1'b1;
                                    end
                                end else begin
                                    state_d = StCrcLo;
                                    sh_d    = ~crc_q[7:0];
                                end
                            end
                            StCrcLo: begin
                                state_d = StCrcHi;
                                sh_d    = ~crc_q[15:8];
                            end
                            default: to_eop = 1'b1;
                        endcase
                        load_bit = sh_d[0];
                    end
                end
            end
        endcase

        if (to_eop) begin
            state_d = StEop;
            eop_d   = '0;
            ones_d  = '0;
            dp_d    = 1'b0;
            dm_d    = 1'b0;
        end else if (load_en) begin
            // NRZI: a 0 toggles the line, a 1 holds it
            lvl_d  = load_bit ? lvl_q : ~lvl_q;
            dp_d   = lvl_d;
            dm_d   = ~lvl_d;
            ones_d = load_bit ? ones_q + 1'b1 : '0;
            if (crc_en) begin
                crc_d = crc_step(crc_q, load_bit);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            sh_q       <= '0;
            bit_q      <= '0;
            ones_q     <= '0;
            crc_q      <= '0;
            byte_cnt_q <= '0;
            pid_q      <= '0;
            eop_q      <= '0;
            lvl_q      <= 1'b1;
            dp_q       <= 1'b1;
            dm_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            sh_q       <= sh_d;
            bit_q      <= bit_d;
            ones_q     <= ones_d;
            crc_q      <= crc_d;
            byte_cnt_q <= byte_cnt_d;
            pid_q      <= pid_d;
            eop_q      <= eop_d;
            lvl_q      <= lvl_d;
            dp_q       <= dp_d;
            dm_q       <= dm_d;
            err_q      <= err_d;
        end
    end

    assign dp_out             = dp_q;
    assign dm_out             = dm_q;
    assign tx_error           = err_q;
    assign tx_transfer_active = (state_q != StIdle);
    assign get_tx_packet_data = pop && !rst;
    assign tx_done            = (state_q == StEop) && (eop_q == 2'd2) && bit_strobe && !rst;

endmodule
